// File: rtl/mem_resp_demux_pkg.sv
// Shared types for the memory response demultiplexer: destination enum and a readiness helper.
package mem_resp_demux_pkg;
  `include "mem_path_defs.vh"

  typedef enum logic {
    DST_IF  = TAG_IF,
    DST_MEM = TAG_MEM
  } dst_e;

  // A 1-entry output register can take a new word if it is empty or draining this cycle.
  function automatic logic dst_free(input logic valid, input logic ready);
    return !valid || ready;
  endfunction
endpackage

// File: rtl/mem_path_defs.vh
// Destination tag encodings shared by the memory request issuer and the response path.
`ifndef MEM_PATH_DEFS_VH
`define MEM_PATH_DEFS_VH
localparam logic TAG_IF  = 1'b0;
localparam logic TAG_MEM = 1'b1;
`endif

// File: rtl/mem_resp_demux_tag_fifo.sv
// 1-bit tag FIFO with wrap pointers (extra MSB) distinguishing full from empty.
module tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     push_tag,
  input  logic                     pop,
  output logic                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        tags [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign head    = tags[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: tag storage is deliberately not reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) tags[wr_ptr[AW-1:0]] <= push_tag;
  end
endmodule

// File: rtl/mem_resp_demux.sv
// Steers memory read data to the IF or MEM consumer using in-order tags recorded at request time.
module mem_resp_demux
  import mem_resp_demux_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_push,
  input  logic                   req_tag,
  output logic                   tag_full,
  output logic [$clog2(DEPTH):0] outstanding,
  input  logic                   resp_valid,
  input  logic [N-1:0]           resp_data,
  output logic                   resp_ready,
  output logic                   if_valid,
  output logic [N-1:0]           if_data,
  input  logic                   if_ready,
  output logic                   mem_valid,
  output logic [N-1:0]           mem_data,
  input  logic                   mem_ready,
  output logic                   err_overflow,
  output logic                   err_orphan
);
  logic head_raw;
  dst_e head;
  logic empty;
  logic head_free;
  logic accept;
  logic load_if;
  logic load_mem;

  tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (req_push),
    .push_tag (req_tag),
    .pop      (accept),
    .head     (head_raw),
    .full     (tag_full),
    .empty    (empty),
    .count    (outstanding)
  );

  assign head = dst_e'(head_raw);

  // Only the head destination's readiness matters; the other one may stall freely.
  always_comb begin
    head_free = 1'b0;
    case (head)
      DST_IF:  head_free = dst_free(if_valid, if_ready);
      DST_MEM: head_free = dst_free(mem_valid, mem_ready);
      default: head_free = 1'b0;
    endcase
  end

  assign resp_ready = !empty && head_free;
  assign accept     = resp_valid && resp_ready;
  assign load_if    = accept && (head == DST_IF);
  assign load_mem   = accept && (head == DST_MEM);

  // Reload wins over drain so a word can leave and arrive in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_valid <= 1'b0;
      if_data  <= '0;
    end else if (load_if) begin
      if_valid <= 1'b1;
      if_data  <= resp_data;
    end else if (if_ready) begin
      if_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_valid <= 1'b0;
      mem_data  <= '0;
    end else if (load_mem) begin
      mem_valid <= 1'b1;
      mem_data  <= resp_data;
    end else if (mem_ready) begin
      mem_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_overflow <= 1'b0;
      err_orphan   <= 1'b0;
    end else begin
      if (req_push && tag_full) err_overflow <= 1'b1;
      if (resp_valid && empty)  err_orphan   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_resp_demux.sv
// Directed self-checking bench for mem_resp_demux (N=32, DEPTH=4).
module tb_mem_resp_demux;
  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_push;
  logic          req_tag;
  logic          tag_full;
  logic [2:0]    outstanding;
  logic          resp_valid;
  logic [N-1:0]  resp_data;
  logic          resp_ready;
  logic          if_valid;
  logic [N-1:0]  if_data;
  logic          if_ready;
  logic          mem_valid;
  logic [N-1:0]  mem_data;
  logic          mem_ready;
  logic          err_overflow;
  logic          err_orphan;

  int n_cmp = 0;
  int n_bad = 0;

  mem_resp_demux #(.N(N), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_push     (req_push),
    .req_tag      (req_tag),
    .tag_full     (tag_full),
    .outstanding  (outstanding),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_ready   (resp_ready),
    .if_valid     (if_valid),
    .if_data      (if_data),
    .if_ready     (if_ready),
    .mem_valid    (mem_valid),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .err_overflow (err_overflow),
    .err_orphan   (err_orphan)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_push   = 1'b0;
    req_tag    = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    if_ready   = 1'b1;
    mem_ready  = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic push_tag(input logic t);
    req_push = 1'b1;
    req_tag  = t;
    tick();
    req_push = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst        = 1'b0;
    resp_valid = 1'b1;
    tick();
    tick();
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    n_cmp++; if (resp_ready !== 1'b0) begin n_bad++; $display("FAIL reset_resp_ready: got %b expected 0", resp_ready); end
    n_cmp++; if ({if_valid, mem_valid, tag_full} !== 3'b000) begin n_bad++; $display("FAIL reset_valids: got %b expected 000", {if_valid, mem_valid, tag_full}); end
    n_cmp++; if ({if_data, mem_data} !== '0) begin n_bad++; $display("FAIL reset_data: got %h/%h expected 0/0", if_data, mem_data); end
    n_cmp++; if ({err_overflow, err_orphan} !== 2'b00) begin n_bad++; $display("FAIL reset_errs: got %b expected 00", {err_overflow, err_orphan}); end
    rst = 1'b1;
    tick();
    n_cmp++; if (err_orphan !== 1'b1) begin n_bad++; $display("FAIL orphan_after_reset: got %b expected 1", err_orphan); end
    n_cmp++; if (resp_ready !== 1'b0) begin n_bad++; $display("FAIL orphan_resp_ready: got %b expected 0", resp_ready); end
    do_reset();
  endtask

  task automatic test_in_order_split();
    do_reset();
    push_tag(1'b0);
    push_tag(1'b1);
    push_tag(1'b0);
    n_cmp++; if (outstanding !== 3'd3) begin n_bad++; $display("FAIL split_outstanding3: got %0d expected 3", outstanding); end
    resp_valid = 1'b1;
    resp_data  = 32'hA1;
    #1;
    n_cmp++; if (resp_ready !== 1'b1) begin n_bad++; $display("FAIL split_resp_ready: got %b expected 1", resp_ready); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL split_latency: got if_valid=%b expected 0", if_valid); end
    tick();
    n_cmp++; if (!(if_valid === 1'b1 && if_data === 32'hA1)) begin n_bad++; $display("FAIL split_if_a1: got v=%b d=%h expected v=1 d=a1", if_valid, if_data); end
    resp_data = 32'hB2;
    tick();
    n_cmp++; if (!(mem_valid === 1'b1 && mem_data === 32'hB2 && if_valid === 1'b0)) begin n_bad++; $display("FAIL split_mem_b2: got mv=%b md=%h iv=%b expected mv=1 md=b2 iv=0", mem_valid, mem_data, if_valid); end
    resp_data = 32'hC3;
    tick();
    n_cmp++; if (!(if_valid === 1'b1 && if_data === 32'hC3 && mem_valid === 1'b0)) begin n_bad++; $display("FAIL split_if_c3: got iv=%b id=%h mv=%b expected iv=1 id=c3 mv=0", if_valid, if_data, mem_valid); end
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL split_outstanding0: got %0d expected 0", outstanding); end
    resp_valid = 1'b0;
    tick();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL split_drain: got if_valid=%b expected 0", if_valid); end
  endtask

  task automatic test_head_stall();
    do_reset();
    mem_ready = 1'b0;
    push_tag(1'b1);
    push_tag(1'b0);
    resp_valid = 1'b1;
    resp_data  = 32'h11;
    tick();
    n_cmp++; if (!(mem_valid === 1'b1 && mem_data === 32'h11)) begin n_bad++; $display("FAIL stall_mem_11: got v=%b d=%h expected v=1 d=11", mem_valid, mem_data); end
    resp_data = 32'h22;
    #1;
    n_cmp++; if (resp_ready !== 1'b1) begin n_bad++; $display("FAIL stall_nonhead_block: got resp_ready=%b expected 1", resp_ready); end
    tick();
    n_cmp++; if (!(if_valid === 1'b1 && if_data === 32'h22 && mem_valid === 1'b1 && mem_data === 32'h11)) begin n_bad++; $display("FAIL stall_if_22: got iv=%b id=%h mv=%b md=%h expected 1/22/1/11", if_valid, if_data, mem_valid, mem_data); end
    resp_valid = 1'b0;
    push_tag(1'b1);
    resp_valid = 1'b1;
    resp_data  = 32'h33;
    #1;
    n_cmp++; if (resp_ready !== 1'b0) begin n_bad++; $display("FAIL stall_head_block: got resp_ready=%b expected 0", resp_ready); end
    tick();
    n_cmp++; if (!(resp_ready === 1'b0 && mem_data === 32'h11 && outstanding === 3'd1)) begin n_bad++; $display("FAIL stall_hold: got rr=%b md=%h out=%0d expected 0/11/1", resp_ready, mem_data, outstanding); end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (resp_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release: got resp_ready=%b expected 1", resp_ready); end
    tick();
    n_cmp++; if (!(mem_valid === 1'b1 && mem_data === 32'h33 && outstanding === 3'd0)) begin n_bad++; $display("FAIL stall_mem_33: got v=%b d=%h out=%0d expected 1/33/0", mem_valid, mem_data, outstanding); end
    resp_valid = 1'b0;
  endtask

  task automatic test_full_overflow();
    do_reset();
    push_tag(1'b0);
    push_tag(1'b1);
    push_tag(1'b0);
    push_tag(1'b1);
    n_cmp++; if (!(tag_full === 1'b1 && outstanding === 3'd4)) begin n_bad++; $display("FAIL full_flag: got full=%b out=%0d expected 1/4", tag_full, outstanding); end
    req_push   = 1'b1;
    req_tag    = 1'b0;
    resp_valid = 1'b1;
    resp_data  = 32'h44;
    tick();
    req_push = 1'b0;
    n_cmp++; if (!(err_overflow === 1'b1 && outstanding === 3'd3 && tag_full === 1'b0)) begin n_bad++; $display("FAIL overflow_drop: got err=%b out=%0d full=%b expected 1/3/0", err_overflow, outstanding, tag_full); end
    n_cmp++; if (if_data !== 32'h44) begin n_bad++; $display("FAIL overflow_pop_data: got %h expected 44", if_data); end
    resp_data = 32'h55;
    tick();
    n_cmp++; if (!(mem_valid === 1'b1 && mem_data === 32'h55)) begin n_bad++; $display("FAIL overflow_next_tag: got v=%b d=%h expected 1/55", mem_valid, mem_data); end
    resp_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] w;
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      req_push   = (k < 16);
      req_tag    = k[0];
      resp_valid = (k >= 1);
      resp_data  = N'(k - 1);
      if (k >= 1) begin
        #1;
        n_cmp++; if (resp_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_bubble_%0d: got resp_ready=%b expected 1", k, resp_ready); end
      end
      tick();
      if (k >= 1) begin
        w = N'(k - 1);
        if (w[0] == 1'b0) begin
          n_cmp++; if (!(if_valid === 1'b1 && if_data === w && mem_valid === 1'b0)) begin n_bad++; $display("FAIL b2b_word_%0d: got iv=%b id=%h mv=%b expected 1/%h/0", k - 1, if_valid, if_data, mem_valid, w); end
        end else begin
          n_cmp++; if (!(mem_valid === 1'b1 && mem_data === w && if_valid === 1'b0)) begin n_bad++; $display("FAIL b2b_word_%0d: got mv=%b md=%h iv=%b expected 1/%h/0", k - 1, mem_valid, mem_data, if_valid, w); end
        end
      end
    end
    idle_inputs();
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL b2b_outstanding: got %0d expected 0", outstanding); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    if_ready = 1'b0;
    push_tag(1'b0);
    push_tag(1'b1);
    push_tag(1'b0);
    push_tag(1'b1);
    push_tag(1'b0);
    resp_valid = 1'b1;
    resp_data  = 32'h66;
    tick();
    resp_valid = 1'b0;
    n_cmp++; if (!(if_valid === 1'b1 && outstanding === 3'd3 && err_overflow === 1'b1)) begin n_bad++; $display("FAIL midrst_setup: got iv=%b out=%0d ovf=%b expected 1/3/1", if_valid, outstanding, err_overflow); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_cmp++; if (!(outstanding === 3'd0 && if_valid === 1'b0 && if_data === '0)) begin n_bad++; $display("FAIL midrst_state: got out=%0d iv=%b id=%h expected 0/0/0", outstanding, if_valid, if_data); end
    n_cmp++; if (!(resp_ready === 1'b0 && err_overflow === 1'b0 && err_orphan === 1'b0)) begin n_bad++; $display("FAIL midrst_flags: got rr=%b ovf=%b orph=%b expected 0/0/0", resp_ready, err_overflow, err_orphan); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_in_order_split();
    test_head_stall();
    test_full_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
